// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C register-access master.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_REG,
    ST_ACK_R,
    ST_WAIT_WR,
    ST_WDATA,
    ST_ACK_W,
    ST_RSTART,
    ST_RADDR,
    ST_ACK_RA,
    ST_RDATA,
    ST_WAIT_RD,
    ST_MACK,
    ST_STOP
  } i2c_state_e;

  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: one-clock tick every CLK_DIV clocks plus a 2-bit
// quarter index; both held at zero while disabled.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       quarter_q, quarter_d;

  always_comb begin
    tick      = en && (div_q == DIV_W'(CLK_DIV - 1));
    div_d     = div_q;
    quarter_d = quarter_q;
    if (!en) begin
      div_d     = '0;
      quarter_d = '0;
    end else if (tick) begin
      div_d     = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      quarter_q <= '0;
    end else begin
      div_q     <= div_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter = quarter_q;

endmodule

// File: rtl/i2c_master_rw.sv
// I2C master performing register writes (addr, reg, data...) and register
// reads (addr, reg, Sr, addr+1, data...) with byte-level valid/ready streams.
module i2c_master_rw
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 125,
  parameter int unsigned MAX_BYTES = 4,
  localparam int unsigned CNT_W    = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             i2c_scl,
  inout  wire              i2c_sda,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       slav_addr,
  input  logic [7:0]       reg_addr,
  input  logic             read_not_write,
  input  logic [CNT_W-1:0] byte_count,
  input  logic [7:0]       write_data,
  input  logic             write_valid,
  output logic             write_ready,
  output logic [7:0]       read_data,
  output logic             read_valid,
  input  logic             read_ready,
  output logic             busy,
  output logic             error
);

  i2c_state_e       state_q, state_d;
  logic [7:0]       shift_q, shift_d, reg_q, reg_d, read_data_q, read_data_d;
  logic [6:0]       addr_q, addr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             rd_q, rd_d, ack_q, ack_d, read_valid_q, read_valid_d, error_q, error_d;
  logic             tick_en, tick, sample, bit_end, last_byte, scl_rel, sda_low;
  logic [1:0]       quarter;

  // The timebase restarts at quarter 0 whenever a stall state is left.
  assign tick_en = (state_q != ST_IDLE) && (state_q != ST_WAIT_WR) && (state_q != ST_WAIT_RD);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (reset),
    .en      (tick_en),
    .tick    (tick),
    .quarter (quarter)
  );

  assign sample    = tick && (quarter == 2'd2);
  assign bit_end   = tick && (quarter == 2'd3);
  assign last_byte = (byte_cnt_q == CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    reg_d        = reg_q;
    addr_d       = addr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    rd_d         = rd_q;
    ack_d        = ack_q;
    read_data_d  = read_data_q;
    read_valid_d = read_valid_q;
    error_d      = error_q;
    if (sample) begin
      ack_d = i2c_sda;
      if (state_q == ST_RDATA) shift_d = {shift_q[6:0], i2c_sda};
    end
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        if ((byte_count == '0) || (byte_count > CNT_W'(MAX_BYTES))) begin
          error_d = 1'b1;
        end else begin
          error_d    = 1'b0;
          rd_d       = read_not_write;
          addr_d     = slav_addr;
          reg_d      = reg_addr;
          byte_cnt_d = byte_count;
          shift_d    = {slav_addr, I2C_WR};
          state_d    = ST_START;
        end
      end
      ST_START, ST_RSTART: if (bit_end) begin
        bit_cnt_d = '0;
        state_d   = (state_q == ST_START) ? ST_ADDR : ST_RADDR;
      end
      ST_ADDR, ST_REG, ST_WDATA, ST_RADDR: if (bit_end) begin
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = '0;
          case (state_q)
            ST_ADDR:  state_d = ST_ACK_A;
            ST_REG:   state_d = ST_ACK_R;
            ST_WDATA: state_d = ST_ACK_W;
            default:  state_d = ST_ACK_RA;
          endcase
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = {shift_q[6:0], 1'b0};
        end
      end
      ST_ACK_A, ST_ACK_R, ST_ACK_W, ST_ACK_RA: if (bit_end) begin
        bit_cnt_d = '0;
        if (ack_q == I2C_NACK) begin
          error_d = 1'b1;
          state_d = ST_STOP;
        end else begin
          case (state_q)
            ST_ACK_A: begin
              shift_d = reg_q;
              state_d = ST_REG;
            end
            ST_ACK_R: begin
              shift_d = {addr_q, I2C_RD};
              state_d = rd_q ? ST_RSTART : ST_WAIT_WR;
            end
            ST_ACK_W: begin
              byte_cnt_d = byte_cnt_q - CNT_W'(1);
              state_d    = last_byte ? ST_STOP : ST_WAIT_WR;
            end
            default: state_d = ST_RDATA;
          endcase
        end
      end
      ST_WAIT_WR: if (write_valid) begin
        shift_d   = write_data;
        bit_cnt_d = '0;
        state_d   = ST_WDATA;
      end
      ST_RDATA: if (bit_end) begin
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d    = '0;
          read_data_d  = shift_q;
          read_valid_d = 1'b1;
          state_d      = ST_WAIT_RD;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_WAIT_RD: if (read_ready && read_valid_q) begin
        read_valid_d = 1'b0;
        state_d      = ST_MACK;
      end
      ST_MACK: if (bit_end) begin
        bit_cnt_d  = '0;
        byte_cnt_d = byte_cnt_q - CNT_W'(1);
        state_d    = last_byte ? ST_STOP : ST_RDATA;
      end
      ST_STOP: if (bit_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Line drive decoded from state and quarter; SCL is high only in q1/q2 of a bit.
  always_comb begin
    scl_rel = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_START: begin
        scl_rel = (quarter != 2'd3);
        sda_low = (quarter >= 2'd2);
      end
      ST_RSTART: begin
        scl_rel = (quarter == 2'd1) || (quarter == 2'd2);
        sda_low = (quarter >= 2'd2);
      end
      ST_STOP: begin
        scl_rel = (quarter != 2'd0);
        sda_low = (quarter <= 2'd1);
      end
      ST_WAIT_WR, ST_WAIT_RD: scl_rel = 1'b0;
      ST_ADDR, ST_REG, ST_WDATA, ST_RADDR: begin
        scl_rel = (quarter == 2'd1) || (quarter == 2'd2);
        sda_low = !shift_q[7];
      end
      ST_MACK: begin
        scl_rel = (quarter == 2'd1) || (quarter == 2'd2);
        sda_low = ((last_byte ? I2C_NACK : I2C_ACK) == I2C_ACK);
      end
      default: scl_rel = (quarter == 2'd1) || (quarter == 2'd2);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      reg_q        <= '0;
      addr_q       <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      rd_q         <= 1'b0;
      ack_q        <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      reg_q        <= reg_d;
      addr_q       <= addr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      rd_q         <= rd_d;
      ack_q        <= ack_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      error_q      <= error_d;
    end
  end

  assign i2c_scl     = scl_rel;
  assign i2c_sda     = sda_low ? 1'b0 : 1'bz;
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign write_ready = (state_q == ST_WAIT_WR);
  assign read_data   = read_data_q;
  assign read_valid  = read_valid_q;
  assign error       = error_q;

endmodule

// File: tb/tb_i2c_master_rw.sv
// Directed bench for i2c_master_rw with a clocked I2C slave/bus monitor.
module tb_i2c_master_rw;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned MAX_BYTES = 4;
  localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             i2c_scl;
  wire              i2c_sda;
  logic             cmd_valid, cmd_ready, read_not_write;
  logic [6:0]       slav_addr;
  logic [7:0]       reg_addr, write_data, read_data;
  logic [CNT_W-1:0] byte_count;
  logic             write_valid, write_ready, read_valid, read_ready, busy, error;

  int vectors = 0;
  int miscompares = 0;

  i2c_master_rw #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk            (clk),
    .reset          (reset),
    .i2c_scl        (i2c_scl),
    .i2c_sda        (i2c_sda),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .slav_addr      (slav_addr),
    .reg_addr       (reg_addr),
    .read_not_write (read_not_write),
    .byte_count     (byte_count),
    .write_data     (write_data),
    .write_valid    (write_valid),
    .write_ready    (write_ready),
    .read_data      (read_data),
    .read_valid     (read_valid),
    .read_ready     (read_ready),
    .busy           (busy),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Open-drain SDA: pull-up plus slave pull-down.
  logic slv_low = 1'b0;
  pullup (i2c_sda);
  assign i2c_sda = slv_low ? 1'b0 : 1'bz;

  // Slave model / monitor, sampled on the falling system clock.
  logic [7:0] mon_q[$];
  logic       mack_q[$];
  logic [7:0] rd_mem [0:15];
  int         rd_idx = 0;
  int         starts = 0, stops = 0, bitn = 0;
  logic       nack_addr = 1'b0;
  logic       ps = 1'b1, pd = 1'b1, s, d, first = 1'b0, slave_tx = 1'b0, rd_mode = 1'b0;
  logic [7:0] sh = '0, cur = '0;

  always @(negedge clk) begin
    s = i2c_scl;
    d = i2c_sda;
    if (reset) begin
      ps = 1'b1; pd = 1'b1; bitn = 0; first = 1'b0; slave_tx = 1'b0; slv_low = 1'b0;
    end else begin
      if (ps && s && pd && !d) begin
        starts++; bitn = 0; first = 1'b1; slave_tx = 1'b0; slv_low = 1'b0;
      end else if (ps && s && !pd && d) begin
        stops++;
      end else if (!ps && s) begin
        if (bitn < 8 && !slave_tx) sh = {sh[6:0], d};
        if (bitn == 8 && slave_tx) mack_q.push_back(d);
        bitn++;
      end else if (ps && !s) begin
        if (bitn == 8) begin
          if (!slave_tx) begin
            mon_q.push_back(sh);
            if (first) begin
              rd_mode = sh[0];
              slv_low = !nack_addr;
            end else begin
              slv_low = 1'b1;
            end
          end else begin
            slv_low = 1'b0;
          end
        end else if (bitn == 9) begin
          bitn = 0;
          slv_low = 1'b0;
          if ((first && rd_mode && !nack_addr) || (slave_tx && mack_q.size() > 0 && mack_q[mack_q.size()-1] == 1'b0)) begin
            slave_tx = 1'b1;
            cur = rd_mem[rd_idx[3:0]];
            rd_idx++;
            slv_low = !cur[7];
          end else begin
            slave_tx = 1'b0;
          end
          first = 1'b0;
        end else if (slave_tx && bitn >= 1 && bitn <= 7) begin
          slv_low = !cur[7-bitn];
        end
      end
      ps = s;
      pd = d;
    end
  end

  int mb, kb, sb, pb, viol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mon_word(input int from);
    logic [31:0] w = '0;
    for (int i = from; i < mon_q.size(); i++) w = {w[23:0], mon_q[i]};
    return w;
  endfunction

  function automatic logic [31:0] mack_word(input int from);
    logic [31:0] w = '0;
    for (int i = from; i < mack_q.size(); i++) w = {w[30:0], mack_q[i]};
    return w;
  endfunction

  task automatic snap();
    mb = mon_q.size(); kb = mack_q.size(); sb = starts; pb = stops; viol = 0;
  endtask

  task automatic cmd(input logic rd, input logic [6:0] a, input logic [7:0] r, input logic [CNT_W-1:0] n);
    @(negedge clk);
    cmd_valid = 1'b1; read_not_write = rd; slav_addr = a; reg_addr = r; byte_count = n;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] data, input int stall);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!write_ready && n < 3000);
    chk("write_ready_seen", {31'd0, write_ready}, 32'd1);
    repeat (stall) begin
      @(negedge clk);
      if (i2c_scl !== 1'b0 || write_ready !== 1'b1) viol++;
    end
    write_data = data; write_valid = 1'b1;
    @(posedge clk);
    #1 write_valid = 1'b0;
  endtask

  task automatic get_byte(input logic [7:0] exp, input int stall);
    int n;
    logic [7:0] d0;
    n = 0;
    do begin @(negedge clk); n++; end while (!read_valid && n < 3000);
    chk("read_valid_seen", {31'd0, read_valid}, 32'd1);
    d0 = read_data;
    repeat (stall) begin
      @(negedge clk);
      if (read_valid !== 1'b1 || read_data !== d0 || i2c_scl !== 1'b0) viol++;
    end
    chk("read_data", {24'd0, read_data}, {24'd0, exp});
    read_ready = 1'b1;
    @(posedge clk);
    #1 read_ready = 1'b0;
    chk("read_valid_clr", {31'd0, read_valid}, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 6000);
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; read_not_write = 1'b0; slav_addr = '0; reg_addr = '0;
    byte_count = '0; write_data = '0; write_valid = 1'b0; read_ready = 1'b0;
    rd_mem[0] = 8'hA1; rd_mem[1] = 8'hB2; rd_mem[2] = 8'hC3; rd_mem[3] = 8'h96; rd_mem[4] = 8'h69;
    for (int i = 5; i < 16; i++) rd_mem[i] = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'd0, i2c_scl}, 32'd1);
    chk("rst_sda", {31'd0, i2c_sda}, 32'd1);
    chk("rst_ctl", {26'd0, cmd_ready, busy, write_ready, read_valid, error, 1'b0}, 32'h20);
    chk("rst_rdata", {24'd0, read_data}, 32'd0);
    reset = 1'b0;

    // Single-byte write
    snap();
    cmd(1'b0, 7'h1A, 8'h05, 3'd1);
    put_byte(8'h3C, 0);
    wait_idle();
    chk("wr_bus", mon_word(mb), 32'h0034053C);
    chk("wr_nbytes", mon_q.size() - mb, 32'd3);
    chk("wr_start_stop", {(starts - sb), (stops - pb)} , {32'd1, 32'd1});
    chk("wr_error", {31'd0, error}, 32'd0);

    // Three-byte read
    snap();
    cmd(1'b1, 7'h1A, 8'h10, 3'd3);
    get_byte(8'hA1, 0);
    get_byte(8'hB2, 0);
    get_byte(8'hC3, 0);
    wait_idle();
    chk("rd_bus", mon_word(mb), 32'h00341035);
    chk("rd_starts", starts - sb, 32'd2);
    chk("rd_stops", stops - pb, 32'd1);
    chk("rd_mack", mack_word(kb), 32'b001);
    chk("rd_mack_n", mack_q.size() - kb, 32'd3);
    chk("rd_error", {31'd0, error}, 32'd0);

    // Write with a 50-tick stall before byte 2
    snap();
    cmd(1'b0, 7'h1A, 8'h22, 3'd2);
    put_byte(8'h5A, 0);
    put_byte(8'hC3, 50 * CLK_DIV);
    wait_idle();
    chk("wstall_viol", viol, 32'd0);
    chk("wstall_bus", mon_word(mb), 32'h34225AC3);
    chk("wstall_stops", stops - pb, 32'd1);

    // Read with a 100-clock read_ready stall after byte 1
    snap();
    cmd(1'b1, 7'h1A, 8'h40, 3'd2);
    get_byte(8'h96, 100);
    get_byte(8'h69, 0);
    wait_idle();
    chk("rstall_viol", viol, 32'd0);
    chk("rstall_mack", mack_word(kb), 32'b01);
    chk("rstall_bus", mon_word(mb), 32'h00344035);

    // Address NACK
    snap();
    nack_addr = 1'b1;
    cmd(1'b0, 7'h2B, 8'h77, 3'd1);
    wait_idle();
    nack_addr = 1'b0;
    chk("nack_error", {31'd0, error}, 32'd1);
    chk("nack_bus", mon_word(mb), 32'h00000056);
    chk("nack_nbytes", mon_q.size() - mb, 32'd1);
    chk("nack_stops", stops - pb, 32'd1);
    snap();
    cmd(1'b0, 7'h1A, 8'h05, 3'd1);
    @(negedge clk);
    chk("err_cleared_on_accept", {30'd0, error, busy}, 32'b01);
    put_byte(8'h81, 0);
    wait_idle();
    chk("after_nack_bus", mon_word(mb), 32'h00340581);

    // Illegal byte counts are dropped with error and no bus activity
    snap();
    cmd(1'b0, 7'h1A, 8'h05, 3'd0);
    @(negedge clk);
    chk("cnt0", {30'd0, error, busy}, 32'b10);
    cmd(1'b1, 7'h1A, 8'h05, 3'd5);
    repeat (40) @(negedge clk);
    chk("cnt5", {30'd0, error, busy}, 32'b10);
    chk("cnt_bad_starts", starts - sb, 32'd0);

    // Reset in the middle of WDATA bit 4
    cmd(1'b0, 7'h1A, 8'h05, 3'd1);
    put_byte(8'hF0, 0);
    repeat (4 * 4 * CLK_DIV + CLK_DIV + 2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_scl", {31'd0, i2c_scl}, 32'd1);
    chk("mid_rst_sda", {31'd0, i2c_sda}, 32'd1);
    chk("mid_rst_ctl", {28'd0, cmd_ready, busy, write_ready, error}, 32'b1000);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    snap();
    cmd(1'b0, 7'h1A, 8'h05, 3'd1);
    put_byte(8'h3C, 0);
    wait_idle();
    chk("post_rst_bus", mon_word(mb), 32'h0034053C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
